// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one synchronous write port,
// optional write-to-read bypass and a per-register pending-writer scoreboard.
module reg_file_sb #(
    parameter int unsigned     XLEN    = 32,
    parameter int unsigned     AW      = 5,
    parameter int unsigned     SP_IDX  = 2,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(1024),
    parameter bit              BYPASS  = 1'b1,
    parameter int unsigned     PW      = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rd1_data,
    output logic [XLEN-1:0] rd2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            alloc_en,
    input  logic [AW-1:0]   alloc_addr,
    output logic            alloc_ready,
    input  logic            flush
);

    localparam int unsigned NREG = 1 << AW;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [PW-1:0]   cnt_q  [NREG];
    logic [PW-1:0]   cnt_d  [NREG];

    logic wr_hit;
    logic alloc_acc;
    logic retire;
    logic same_reg;

    assign wr_hit      = wr_en && (wr_addr != '0);
    assign alloc_ready = !flush && ((alloc_addr == '0) || (cnt_q[alloc_addr] != '1));
    assign alloc_acc   = alloc_en && alloc_ready && (alloc_addr != '0);
    // A write to an idle register still commits data but must not underflow.
    assign retire      = wr_hit && (cnt_q[wr_addr] != '0);
    assign same_reg    = alloc_acc && retire && (alloc_addr == wr_addr);

    always_comb begin
        regs_d = regs_q;
        if (wr_hit) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                cnt_d[i] = '0;
            end
        end else if (!same_reg) begin
            if (alloc_acc) begin
                cnt_d[alloc_addr] = cnt_q[alloc_addr] + 1'b1;
            end
            if (retire) begin
                cnt_d[wr_addr] = cnt_q[wr_addr] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        rd1_data = regs_q[rs1];
        if (rs1 == '0) begin
            rd1_data = '0;
        end else if (BYPASS && wr_hit && (wr_addr == rs1)) begin
            rd1_data = wr_data;
        end
    end

    always_comb begin
        rd2_data = regs_q[rs2];
        if (rs2 == '0) begin
            rd2_data = '0;
        end else if (BYPASS && wr_hit && (wr_addr == rs2)) begin
            rd2_data = wr_data;
        end
    end

    // With bypass, the last outstanding writer retiring this cycle already
    // supplies the operand, so the reader need not stall.
    always_comb begin
        rs1_busy = (rs1 != '0) && (cnt_q[rs1] != '0);
        if (BYPASS && wr_en && (wr_addr == rs1) && (cnt_q[rs1] == PW'(1))) begin
            rs1_busy = 1'b0;
        end
    end

    always_comb begin
        rs2_busy = (rs2 != '0) && (cnt_q[rs2] != '0);
        if (BYPASS && wr_en && (wr_addr == rs2) && (cnt_q[rs2] == PW'(1))) begin
            rs2_busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: bypass and non-bypass instances on shared stimulus,
// checked every cycle against an array-based model plus directed literals.
module tb_reg_file_sb;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int PW   = 2;
    localparam int NREG = 32;
    localparam int CMAX = (1 << PW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   rs1 = '0, rs2 = '0, wr_addr = '0, alloc_addr = '0;
    logic [XLEN-1:0] wr_data = '0;
    logic            wr_en = 1'b0, alloc_en = 1'b0, flush = 1'b0;

    logic [XLEN-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic            busy1_b, busy2_b, busy1_n, busy2_n, ready_b, ready_n;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    logic [XLEN-1:0] mregs [NREG];
    int              mcnt  [NREG];

    reg_file_sb #(.XLEN(XLEN), .AW(AW), .SP_IDX(2), .SP_INIT(32'd1024),
                  .BYPASS(1'b1), .PW(PW)) u_dut_b (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
        .rd1_data(rd1_b), .rd2_data(rd2_b), .rs1_busy(busy1_b), .rs2_busy(busy2_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_ready(ready_b),
        .flush(flush));

    reg_file_sb #(.XLEN(XLEN), .AW(AW), .SP_IDX(2), .SP_INIT(32'd1024),
                  .BYPASS(1'b0), .PW(PW)) u_dut_n (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
        .rd1_data(rd1_n), .rd2_data(rd2_n), .rs1_busy(busy1_n), .rs2_busy(busy2_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_ready(ready_n),
        .flush(flush));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NREG; i++) begin
            mregs[i] = (i == 2) ? 32'd1024 : 32'd0;
            mcnt[i]  = 0;
        end
    endtask

    function automatic logic exp_ready();
        return !flush && (alloc_addr == 0 || mcnt[alloc_addr] < CMAX);
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] rs, input bit byp);
        if (rs == 0) return '0;
        if (byp && wr_en && wr_addr == rs) return wr_data;
        return mregs[rs];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] rs, input bit byp);
        if (rs == 0 || mcnt[rs] == 0) return 1'b0;
        if (byp && wr_en && wr_addr == rs && mcnt[rs] == 1) return 1'b0;
        return 1'b1;
    endfunction

    // Reference state update: every decision uses pre-edge counts.
    always @(posedge clk or negedge rst) begin
        int  aa, wa;
        bit  acc, ret;
        if (!rst) begin
            m_reset();
        end else begin
            aa  = int'(alloc_addr);
            wa  = int'(wr_addr);
            acc = alloc_en && exp_ready() && aa != 0;
            ret = wr_en && wa != 0 && mcnt[wa] > 0;
            if (wr_en && wa != 0) mregs[wa] = wr_data;
            if (flush) begin
                for (int i = 0; i < NREG; i++) mcnt[i] = 0;
            end else begin
                if (acc) mcnt[aa] = mcnt[aa] + 1;
                if (ret) mcnt[wa] = mcnt[wa] - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("rd1_b",   rd1_b,   exp_rd(rs1, 1'b1));
            chk("rd2_b",   rd2_b,   exp_rd(rs2, 1'b1));
            chk("rd1_n",   rd1_n,   exp_rd(rs1, 1'b0));
            chk("rd2_n",   rd2_n,   exp_rd(rs2, 1'b0));
            chk("busy1_b", 32'(busy1_b), 32'(exp_busy(rs1, 1'b1)));
            chk("busy2_b", 32'(busy2_b), 32'(exp_busy(rs2, 1'b1)));
            chk("busy1_n", 32'(busy1_n), 32'(exp_busy(rs1, 1'b0)));
            chk("busy2_n", 32'(busy2_n), 32'(exp_busy(rs2, 1'b0)));
            chk("ready_b", 32'(ready_b), 32'(exp_ready()));
            chk("ready_n", 32'(ready_n), 32'(exp_ready()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        wr_en = 1'b0; alloc_en = 1'b0; flush = 1'b0;
    endtask

    task automatic wr(input int a, input logic [XLEN-1:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 4) != 0) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, NREG - 1));
    endfunction

    initial begin
        m_reset();
        idle();
        #1 rst = 1'b0;
        rs1 = 5'd2; rs2 = 5'd5;
        chk_on = 1'b1;
        settle();
        chk("rst_sp",    rd1_b, 32'd1024);
        chk("rst_sp_n",  rd1_n, 32'd1024);
        chk("rst_x5",    rd2_b, 32'd0);
        chk("rst_busy",  32'(busy1_b | busy2_b | busy1_n | busy2_n), 32'd0);
        chk("rst_ready", 32'(ready_b), 32'd1);
        flush = 1'b1;
        #1 chk("rst_ready_flush", 32'(ready_b), 32'd0);
        flush = 1'b0;
        tick();
        rst = 1'b1;

        wr(5, 32'hDEADBEEF);
        tick(); idle(); settle();
        chk("wr_x5_b", rd2_b, 32'hDEADBEEF);
        chk("wr_x5_n", rd2_n, 32'hDEADBEEF);

        rs1 = 5'd0; wr(0, 32'h1234);
        tick(); idle(); settle();
        chk("x0_read", rd1_b, 32'd0);
        alloc_en = 1'b1; alloc_addr = 5'd0; settle();
        chk("x0_ready", 32'(ready_b), 32'd1);
        tick(); idle(); settle();
        chk("x0_busy", 32'(busy1_b), 32'd0);

        rs1 = 5'd7; wr(7, 32'hA5); settle();
        chk("byp_same_b", rd1_b, 32'hA5);
        chk("byp_same_n", rd1_n, 32'h0);
        tick(); idle(); settle();
        chk("byp_next_n", rd1_n, 32'hA5);

        rs1 = 5'd3; alloc_en = 1'b1; alloc_addr = 5'd3;
        for (int k = 0; k < 3; k++) begin
            settle(); chk("sat_ready", 32'(ready_b), 32'd1); tick();
        end
        settle();
        chk("sat_busy_b", 32'(busy1_b), 32'd1);
        chk("sat_busy_n", 32'(busy1_n), 32'd1);
        chk("sat_full_b", 32'(ready_b), 32'd0);
        chk("sat_full_n", 32'(ready_n), 32'd0);
        tick(); alloc_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wr(3, 32'(k + 1)); settle();
            chk("sat_drain_b", 32'(busy1_b), (k < 2) ? 32'd1 : 32'd0);
            chk("sat_drain_n", 32'(busy1_n), 32'd1);
            tick();
        end
        idle(); settle();
        chk("sat_done_b", 32'(busy1_b), 32'd0);
        chk("sat_done_n", 32'(busy1_n), 32'd0);
        chk("sat_data",   rd1_n, 32'd3);

        alloc_en = 1'b1; alloc_addr = 5'd4; tick();
        rs2 = 5'd4; wr(4, 32'h44); settle();
        chk("ar_busy_n", 32'(busy2_n), 32'd1);
        chk("ar_busy_b", 32'(busy2_b), 32'd0);
        tick(); idle(); settle();
        chk("ar_keep_b", 32'(busy2_b), 32'd1);
        chk("ar_keep_n", 32'(busy2_n), 32'd1);
        chk("ar_data",   rd2_n, 32'h44);
        wr(4, 32'h0); tick();
        wr(4, 32'h99); tick(); idle(); settle();
        chk("under_data", rd2_n, 32'h99);
        chk("under_busy", 32'(busy2_n), 32'd0);

        alloc_en = 1'b1; alloc_addr = 5'd6; tick(); tick();
        alloc_en = 1'b0; rs1 = 5'd6; settle();
        chk("fl_pre_busy", 32'(busy1_n), 32'd1);
        flush = 1'b1; wr(6, 32'h55); alloc_en = 1'b1; settle();
        chk("fl_ready_b", 32'(ready_b), 32'd0);
        chk("fl_ready_n", 32'(ready_n), 32'd0);
        tick(); idle(); settle();
        chk("fl_busy_b", 32'(busy1_b), 32'd0);
        chk("fl_busy_n", 32'(busy1_n), 32'd0);
        chk("fl_data",   rd1_b, 32'h55);

        repeat (3000) begin
            rst        = ($urandom_range(0, 199) != 0);
            rs1        = rnd_addr();
            rs2        = rnd_addr();
            wr_en      = ($urandom_range(0, 9) < 4);
            wr_addr    = rnd_addr();
            wr_data    = $urandom;
            alloc_en   = ($urandom_range(0, 1) == 1);
            alloc_addr = rnd_addr();
            flush      = ($urandom_range(0, 29) == 0);
            tick();
        end
        rst = 1'b1; idle();
        tick();
        chk_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
